// File: rtl/reg_file_wb.sv
// reg_file_wb: RV32I architectural register file with a per-register load scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN enables same-cycle writeback-to-read forwarding.
module reg_file_wb #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_en,
  input  logic [4:0]          wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                wb_load,
  input  logic [4:0]          rs1_addr,
  input  logic [4:0]          rs2_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  input  logic                iss_valid,
  input  logic [4:0]          iss_rd,
  input  logic                iss_load,
  input  logic                iss_use_rs1,
  input  logic                iss_use_rs2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [XLEN-1:0]     regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_eff_s;
  logic [NUM_REGS-1:0] clr_s;
  logic [NUM_REGS-1:0] set_s;
  logic                raw1_s;
  logic                raw2_s;
  logic                waw_s;
  logic                stall_s;
`ifdef REGFILE_WB_BYPASS_EN
  logic [NUM_REGS-1:0] release_s;
`endif

  // Effective busy view used for hazard detection
  always_comb begin
`ifdef REGFILE_WB_BYPASS_EN
    release_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      release_s[r] = wb_en & wb_load & (wb_addr == 5'(r));
    end
    // A load completing this cycle frees its dependents immediately
    busy_eff_s = busy_r & ~release_s;
`else
    busy_eff_s = busy_r;
`endif
  end

  // Operand read port 1
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (!rst_n || rs1_addr == 5'd0) begin
      rs1_data = {XLEN{1'b0}};
    end
`ifdef REGFILE_WB_BYPASS_EN
    else if (wb_en && wb_addr == rs1_addr) begin
      rs1_data = wb_data;
    end
`endif
    else begin
      rs1_data = regs_r[rs1_addr];
    end
  end

  // Operand read port 2
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (!rst_n || rs2_addr == 5'd0) begin
      rs2_data = {XLEN{1'b0}};
    end
`ifdef REGFILE_WB_BYPASS_EN
    else if (wb_en && wb_addr == rs2_addr) begin
      rs2_data = wb_data;
    end
`endif
    else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

  // RAW / WAW hazard detection and issue stall
  always_comb begin
    raw1_s  = iss_use_rs1 & busy_eff_s[rs1_addr];
    raw2_s  = iss_use_rs2 & busy_eff_s[rs2_addr];
    waw_s   = busy_eff_s[iss_rd] & (iss_rd != 5'd0);
    stall_s = rst_n & iss_valid & (raw1_s | raw2_s | waw_s);
  end

  // Scoreboard set/clear decode; x0 can never become busy
  always_comb begin
    clr_s = {NUM_REGS{1'b0}};
    set_s = {NUM_REGS{1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      clr_s[r] = wb_en & wb_load & (wb_addr == 5'(r));
      set_s[r] = iss_valid & ~stall_s & iss_load & (iss_rd == 5'(r));
    end
  end

  // Scoreboard state; set applied after clear so a same-cycle reissue wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= (busy_r & ~clr_s) | set_s;
    end
  end

  // Register storage; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wb_en && wb_addr != 5'd0) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  assign stall    = stall_s;
  assign busy_vec = busy_r;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: directed scenarios plus random traffic vs. a reference model.
// Honours REGFILE_WB_BYPASS_EN the same way as the design.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_load;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_load;
  logic        iss_use_rs1;
  logic        iss_use_rs2;
  logic        stall;
  logic [31:0] busy_vec;

  reg_file_wb dut (
    .clk(clk), .rst_n(rst_n),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_load(wb_load),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_load(iss_load),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        st;
    logic [31:0] bv;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference architectural state
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic bit eff_busy(input int r);
    return m_busy[r] && !(BYPASS && wb_en && wb_load && int'(wb_addr) == r);
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (!rst_n || a == 0) return 32'd0;
    if (BYPASS && wb_en && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  // One clock cycle: drive inputs, queue the expected response, advance the model
  task automatic cyc(input bit rst, input bit wen, input int wa, input logic [31:0] wd,
                     input bit wl, input int a1, input int a2, input bit iv, input int rd,
                     input bit il, input bit u1, input bit u2);
    exp_t e;
    bit   st;
    @(posedge clk);
    #1;
    rst_n = rst; wb_en = wen; wb_addr = 5'(wa); wb_data = wd; wb_load = wl;
    rs1_addr = 5'(a1); rs2_addr = 5'(a2);
    iss_valid = iv; iss_rd = 5'(rd); iss_load = il; iss_use_rs1 = u1; iss_use_rs2 = u2;
    st = rst && iv && ((u1 && eff_busy(a1)) || (u2 && eff_busy(a2)) ||
                       (rd != 0 && eff_busy(rd)));
    e.r1 = model_read(a1);
    e.r2 = model_read(a2);
    e.st = st;
    for (int i = 0; i < 32; i++) e.bv[i] = m_busy[i];
    exp_q.push_back(e);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wen && wa != 0) m_regs[wa] = wd;
      if (wen && wl) m_busy[wa] = 1'b0;
      if (iv && !st && il && rd != 0) m_busy[rd] = 1'b1;
    end
  endtask

  task automatic idle(input int a1, input int a2);
    cyc(1, 0, 0, 32'd0, 0, a1, a2, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp += 4;
        if (rs1_data !== e.r1) begin
          n_bad++;
          $display("FAIL rs1_data: got %h expected %h at %0t", rs1_data, e.r1, $time);
        end
        if (rs2_data !== e.r2) begin
          n_bad++;
          $display("FAIL rs2_data: got %h expected %h at %0t", rs2_data, e.r2, $time);
        end
        if (stall !== e.st) begin
          n_bad++;
          $display("FAIL stall: got %b expected %b at %0t", stall, e.st, $time);
        end
        if (busy_vec !== e.bv) begin
          n_bad++;
          $display("FAIL busy_vec: got %h expected %h at %0t", busy_vec, e.bv, $time);
        end
      end
    end
  end

  initial begin
    bit rs;
    int wa, rd;
    rst_n = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_load = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; iss_valid = 1'b0; iss_rd = 5'd0;
    iss_load = 1'b0; iss_use_rs1 = 1'b0; iss_use_rs2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    // First reset edge establishes known state before anything is checked
    @(posedge clk);
    @(posedge clk);

    // Reset held: traffic ignored, all reads zero
    for (int i = 0; i < 32; i++)
      cyc(0, 1, i, $urandom, 1, i, 31 - i, 1, i, 1, 1, 1);
    for (int i = 0; i < 32; i++) idle(i, 31 - i);

    // Basic write / read, x0 immutable
    cyc(1, 1, 5, 32'hDEADBEEF, 0, 5, 0, 0, 0, 0, 0, 0);
    idle(5, 0);
    cyc(1, 1, 0, 32'h00001234, 0, 5, 0, 0, 0, 0, 0, 0);
    idle(0, 0);

    // Load x7, RAW dependent, load completion
    cyc(1, 0, 0, 32'd0, 0, 0, 0, 1, 7, 1, 0, 0);
    cyc(1, 0, 0, 32'd0, 0, 7, 0, 1, 0, 0, 1, 0);
    cyc(1, 1, 7, 32'h00000055, 1, 7, 0, 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 32'd0, 0, 7, 0, 1, 0, 0, 1, 0);
    idle(7, 7);

    // Same-cycle clear and set on x9 (x9 idle, then x9 busy)
    cyc(1, 1, 9, 32'h00000099, 1, 9, 0, 1, 9, 1, 0, 0);
    idle(9, 0);
    cyc(1, 1, 9, 32'h00000999, 1, 9, 0, 1, 9, 1, 0, 0);
    idle(9, 0);
    cyc(1, 1, 9, 32'h00009999, 1, 9, 0, 0, 0, 0, 0, 0);

    // WAW: non-load to x3 while a load to x3 is outstanding
    cyc(1, 0, 0, 32'd0, 0, 0, 0, 1, 3, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 32'd0, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc(1, 1, 3, 32'h33333333, 1, 3, 0, 1, 3, 0, 0, 0);
    cyc(1, 0, 0, 32'd0, 0, 3, 0, 1, 3, 0, 0, 0);

    // Reset while a load on x12 is outstanding
    cyc(1, 0, 0, 32'd0, 0, 0, 0, 1, 12, 1, 0, 0);
    idle(12, 5);
    cyc(0, 0, 0, 32'd0, 0, 12, 5, 0, 0, 0, 0, 0);
    idle(12, 5);
    cyc(1, 1, 12, 32'h000000A5, 1, 12, 0, 0, 0, 0, 0, 0);
    idle(12, 12);

    // Random traffic; narrow address ranges make hazards frequent
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 49) != 0);
      wa = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      rd = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      cyc(rs, $urandom_range(0, 1) != 0, wa, $urandom, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9), $urandom_range(0, 31),
          $urandom_range(0, 3) != 0, rd, $urandom_range(0, 1) != 0,
          $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Architectural register file with integer scoreboard, consuming the writeback-select output of the RV32I datapath. It is the receiving end of the writeback path: it commits the selected 32-bit result (ALU, load data, PC+4, AUIPC) into x1..x31 and serves two combinational operand read ports to decode. A per-register busy scoreboard tracks outstanding multi-cycle loads and raises a stall toward issue on RAW/WAW hazards.

## Interface
- NUM_REGS, 32, architectural register count; address width 5.
- XLEN, 32, data width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- wb_en  in  1  commit wb_data to wb_addr this cycle.
- wb_addr  in  5  destination register of the writeback.
- wb_data  in  32  value from the writeback select.
- wb_load  in  1  this writeback completes an outstanding load; clears busy[wb_addr].
- rs1_addr, rs2_addr  in  5 each  operand read addresses.
- rs1_data, rs2_data  out  32 each  operand read data, combinational.
- iss_valid  in  1  decode attempting to issue an instruction.
- iss_rd  in  5  destination of the issuing instruction.
- iss_load  in  1  issuing instruction is a load; sets busy[iss_rd] when issue fires.
- iss_use_rs1, iss_use_rs2  in  1 each  instruction reads the operand.
- stall  out  1  issue blocked this cycle.
- busy_vec  out  32  scoreboard state, bit 0 always 0.

## Operation
- Storage: x0 reads 0; writes to x0 ignored; x0 never marked busy.
- Write: on clk edge with rst_n=1 and wb_en=1 and wb_addr!=0, regs[wb_addr] <= wb_data.
- Read: rsN_data = regs[rsN_addr], 0 when rsN_addr==0 or rst_n=0.
- Scoreboard: busy[r] set on edge when iss_valid & ~stall & iss_load & iss_rd==r & r!=0; cleared on edge when wb_en & wb_load & wb_addr==r. Set and clear to the same r in one cycle: set wins (busy stays 1).
- Hazard terms: raw1 = iss_use_rs1 & busy_eff[rs1_addr]; raw2 likewise; waw = busy_eff[iss_rd] & iss_rd!=0.
- stall = iss_valid & (raw1 | raw2 | waw); 0 while rst_n=0.
- busy_eff defined under Configuration.
- Non-load writebacks (wb_load=0) never touch busy bits.

## Timing
- Write latency 1 cycle: value visible on read port the cycle after the commit edge (unless bypass enabled).
- Busy set visible on busy_vec/stall the cycle after issue fires.
- Reset: on edge with rst_n=0, all regs <= 0, busy <= 0; wb and issue inputs ignored that edge. While rst_n=0, rs1_data=rs2_data=0, stall=0, busy_vec reflects register (0 after first reset edge).
- Reset mid-load: busy cleared; a later wb_load for that register is a plain write, no error.
- Same-cycle writes and reads to different addresses are independent.

## Configuration
- Macro REGFILE_WB_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding. If wb_en & wb_addr==rsN_addr & wb_addr!=0, rsN_data = wb_data. busy_eff[r] = busy[r] & ~(wb_en & wb_load & wb_addr==r): a completing load releases its dependent in the same cycle.
- Undefined: rsN_data always from storage; busy_eff = busy; dependent stalls one extra cycle after load writeback.

## Test plan
- Reset then read all 32 addresses -> every rsN_data = 0, busy_vec = 0, stall = 0.
- wb_en=1, wb_addr=5, wb_data=0xDEADBEEF; next cycle rs1_addr=5 -> 0xDEADBEEF; write to x0 with 0x1234 -> rs2_addr=0 reads 0.
- Issue load iss_rd=7; next cycle iss_valid, iss_use_rs1, rs1_addr=7 -> stall=1, busy_vec[7]=1; wb_en, wb_load, wb_addr=7, data 0x55 -> with bypass stall=0 and rs1_data=0x55 that cycle; without bypass stall=1 that cycle, 0 next with rs1_data=0x55.
- Same cycle: wb_load completes x9 while a new load issues to x9 -> busy_vec[9]=1 next cycle.
- Issue load to x3, then non-load instruction with iss_rd=3 -> stall=1 (WAW) until load writeback.
- Load outstanding on x12, assert rst_n=0 for one edge -> busy_vec=0, regs 0; subsequent wb_load to x12 with 0xA5 writes 0xA5, busy_vec stays 0.
